// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a one-entry skid buffer,
// synchronous flush and saturating bubble/stall counters.
module if_id_skid_stage #(
    parameter int             N   = 32,
    parameter int             PCW = 32,
    parameter logic [N-1:0]   NOP = {N{1'b0}},
    parameter int             CW  = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [N-1:0]   in_instr,
    input  logic [PCW-1:0] in_pc,
    output logic           in_ready,
    output logic           out_valid,
    output logic [N-1:0]   out_instr,
    output logic [PCW-1:0] out_pc,
    input  logic           out_ready,
    output logic [CW-1:0]  bubble_cnt,
    output logic [CW-1:0]  stall_cnt
);

    // state    | meaning
    // ST_EMPTY | nothing held, NOP on outputs, accepting
    // ST_FULL  | main valid, accepting
    // ST_SKID  | main and skid valid, not accepting
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t           state_q;
    logic [N-1:0]     main_instr_q, skid_instr_q;
    logic [PCW-1:0]   main_pc_q, skid_pc_q;
    logic [CW-1:0]    bubble_q, bubble_d;
    logic [CW-1:0]    stall_q, stall_d;

    // Handshake outputs decode the registered state only.
    assign in_ready   = (state_q != ST_SKID);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_instr  = out_valid ? main_instr_q : NOP;
    assign out_pc     = out_valid ? main_pc_q : '0;
    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;

    always_comb begin
        bubble_d = bubble_q;
        stall_d  = stall_q;
        if (out_ready && !out_valid && (bubble_q != CNT_MAX))
            bubble_d = bubble_q + CNT_ONE;
        if (out_valid && !out_ready && (stall_q != CNT_MAX))
            stall_d = stall_q + CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            bubble_q     <= '0;
            stall_q      <= '0;
        end else begin
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
            // Flush drops everything held plus any beat offered this cycle.
            if (flush) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_valid) begin
                            main_instr_q <= in_instr;
                            main_pc_q    <= in_pc;
                            state_q      <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (in_valid && out_ready) begin
                            main_instr_q <= in_instr;
                            main_pc_q    <= in_pc;
                        end else if (in_valid) begin
                            skid_instr_q <= in_instr;
                            skid_pc_q    <= in_pc;
                            state_q      <= ST_SKID;
                        end else if (out_ready) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (out_ready) begin
                            main_instr_q <= skid_instr_q;
                            main_pc_q    <= skid_pc_q;
                            state_q      <= ST_FULL;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: directed scenarios plus random traffic
// checked against a two-deep in-order queue model.
module tb_if_id_skid_stage;

    localparam int          N      = 32;
    localparam int          PCW    = 32;
    localparam logic [31:0] NOPW   = 32'h0000_0013;
    localparam int          CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;

    logic           clock;
    logic           reset, flush, in_valid, out_ready;
    logic [N-1:0]   in_instr;
    logic [PCW-1:0] in_pc;
    logic           in_ready, out_valid;
    logic [N-1:0]   out_instr;
    logic [PCW-1:0] out_pc;
    logic [CW-1:0]  bubble_cnt, stall_cnt;

    if_id_skid_stage #(.N(N), .PCW(PCW), .NOP(NOPW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [N-1:0]   instr;
        logic [PCW-1:0] pc;
    } beat_t;

    beat_t exp_q[$];
    int    bub_m, stl_m;
    int    errors, checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model. Runs on the falling edge where inputs and
    // outputs are stable; the stage holds the oldest unretired accepted beats
    // (at most two), so the output is the queue head.
    always @(negedge clock) begin
        int    pre;
        beat_t e;
        if (reset) begin
            exp_q.delete();
            bub_m = 0;
            stl_m = 0;
        end else begin
            pre = exp_q.size();
            chk("out_valid", out_valid, 64'(pre > 0));
            chk("in_ready", in_ready, 64'(pre < 2));
            chk("bubble_cnt", bubble_cnt, 64'(bub_m));
            chk("stall_cnt", stall_cnt, 64'(stl_m));
            if (pre == 0) begin
                chk("idle_instr_nop", out_instr, NOPW);
                chk("idle_pc_zero", out_pc, 0);
            end else begin
                e = exp_q[0];
                chk("out_instr", out_instr, e.instr);
                chk("out_pc", out_pc, e.pc);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (out_ready && pre == 0 && bub_m < CMAX) bub_m++;
            if (!out_ready && pre > 0 && stl_m < CMAX) stl_m++;
            if (flush) exp_q.delete();
            else if (in_valid && pre < 2) begin
                e.instr = in_instr;
                e.pc    = in_pc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offers one beat and holds it until the stage takes it.
    task automatic send(input logic [31:0] ins, input logic [31:0] p);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = p;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: beat %0h not accepted, expected acceptance within 50 cycles", ins);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step(); step();
        reset = 1'b0;

        // Stream with decode always ready.
        out_ready = 1'b1;
        send(32'h11, 32'd0);
        send(32'h22, 32'd4);
        send(32'h33, 32'd8);
        repeat (3) step();

        // Back-pressure into the skid register.
        out_ready = 1'b0;
        send(32'hA1, 32'h100);
        send(32'hA2, 32'h104);
        in_valid = 1'b1; in_instr = 32'hA3; in_pc = 32'h108;
        repeat (3) step();
        chk("skid_in_ready_low", in_ready, 0);
        chk("skid_holds_a1", out_instr, 32'hA1);
        out_ready = 1'b1;
        step();
        chk("restart_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Flush while in SKID with a beat offered.
        out_ready = 1'b0;
        send(32'hB1, 32'h200);
        send(32'hB2, 32'h204);
        in_valid = 1'b1; in_instr = 32'hB3; in_pc = 32'h208; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_instr", out_instr, NOPW);
        chk("flush_out_pc", out_pc, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();

        // Reset and flush together while FULL.
        out_ready = 1'b0;
        send(32'hC1, 32'h300);
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0;
        chk("rstflush_out_valid", out_valid, 0);
        chk("rstflush_out_instr", out_instr, NOPW);
        chk("rstflush_in_ready", in_ready, 1);
        chk("rstflush_bubble", bubble_cnt, 0);
        chk("rstflush_stall", stall_cnt, 0);

        // Stall counter saturation.
        send(32'hD1, 32'h400);
        repeat (20) step();
        chk("stall_saturated", stall_cnt, 15);
        out_ready = 1'b1;
        repeat (2) step();

        // Bubble counting from a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("bubble_five", bubble_cnt, 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = $urandom;
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
